// File: rtl/tcbus_protocol_monitor.sv
// tcbus_protocol_monitor: passive tc-bus checker tracking outstanding transactions and flagging protocol errors
// Ports: clk_bus/rst_n (async active-low) clock and reset; tc_req, tc_rnw, tc_addr, tc_wdata,
//   tc_aack, tc_rack, tc_wack observed bus signals; err_clr clears sticky errors;
//   pending_rd/pending_wr outstanding counts; full at MAX_OUTSTANDING; err_status sticky
//   error bits; first_err index of first error; err_irq OR of err_status.
// Define TCBUS_MON_SVA_EN to compile in the assertion and cover properties.
module tcbus_protocol_monitor #(
  parameter int TC_AWIDTH       = 8,
  parameter int TC_DWIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3,
  parameter int TIMEOUT         = 64,
  parameter int TO_W            = 7
) (
  input  logic                 clk_bus,
  input  logic                 rst_n,
  input  logic                 tc_req,
  input  logic                 tc_rnw,
  input  logic [TC_AWIDTH-1:0] tc_addr,
  input  logic [TC_DWIDTH-1:0] tc_wdata,
  input  logic                 tc_aack,
  input  logic                 tc_rack,
  input  logic                 tc_wack,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     pending_rd,
  output logic [CNT_W-1:0]     pending_wr,
  output logic                 full,
  output logic [9:0]           err_status,
  output logic [3:0]           first_err,
  output logic                 err_irq
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  logic                 rd_acc, wr_acc, open_q;
  logic                 req_q, aack_q, rnw_q;
  logic [TC_AWIDTH-1:0] addr_q;
  logic [TC_DWIDTH-1:0] wdata_q;
  logic [TO_W-1:0]      req_wait, rd_wait, wr_wait;
  logic [9:0]           det, err_nxt;
  logic [3:0]           det_idx;

  function automatic logic [CNT_W-1:0] cnt_nxt(input logic [CNT_W-1:0] c, input logic a, input logic k);
    return a ? ((k || c == CNT_MAX) ? c : c + 1'b1) : k ? ((c == '0) ? c : c - 1'b1) : c;
  endfunction

  function automatic logic [TO_W-1:0] wait_nxt(input logic [TO_W-1:0] w, input logic run);
    return run ? ((w == TO_LIM) ? w : w + 1'b1) : '0;
  endfunction

  assign rd_acc  = tc_req & tc_aack & tc_rnw;
  assign wr_acc  = tc_req & tc_aack & ~tc_rnw;
  assign open_q  = req_q & ~aack_q;
  assign full    = ({1'b0, pending_rd} + {1'b0, pending_wr}) == (CNT_W+1)'(MAX_OUTSTANDING);
  assign err_nxt = err_clr ? det : err_status | det;

  always_comb begin
    det[0] = tc_aack & full;
    det[1] = tc_aack & ~tc_req;
    det[2] = tc_rack & (pending_rd == '0) & ~rd_acc;
    det[3] = tc_wack & (pending_wr == '0) & ~wr_acc;
    det[4] = open_q & ~tc_req;
    det[5] = open_q & tc_req & (tc_addr != addr_q);
    det[6] = open_q & tc_req & (tc_rnw != rnw_q);
    det[7] = open_q & tc_req & ~rnw_q & (tc_wdata != wdata_q);
    det[8] = req_wait == TO_LIM;
    det[9] = (rd_wait == TO_LIM) | (wr_wait == TO_LIM);
  end

  always_comb begin
    det_idx = '0;
    for (int i = 9; i >= 0; i--)
      if (det[i]) det_idx = 4'(i);
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      pending_rd <= '0;
      pending_wr <= '0;
      req_q      <= 1'b0;
      aack_q     <= 1'b0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_wait   <= '0;
      rd_wait    <= '0;
      wr_wait    <= '0;
      err_status <= '0;
      first_err  <= '0;
      err_irq    <= 1'b0;
    end else begin
      pending_rd <= cnt_nxt(pending_rd, rd_acc, tc_rack);
      pending_wr <= cnt_nxt(pending_wr, wr_acc, tc_wack);
      req_q      <= tc_req;
      aack_q     <= tc_aack;
      rnw_q      <= tc_rnw;
      addr_q     <= tc_addr;
      wdata_q    <= tc_wdata;
      req_wait   <= wait_nxt(req_wait, tc_req & ~tc_aack);
      rd_wait    <= wait_nxt(rd_wait, (pending_rd != '0) & ~tc_rack);
      wr_wait    <= wait_nxt(wr_wait, (pending_wr != '0) & ~tc_wack);
      err_status <= err_nxt;
      err_irq    <= |err_nxt;
      first_err  <= ((err_clr || err_status == '0) && det != '0) ? det_idx : (err_clr ? '0 : first_err);
    end
  end

`ifdef TCBUS_MON_SVA_EN
  default clocking cb @(posedge clk_bus); endclocking
  default disable iff (!rst_n);
  for (genvar i = 0; i < 10; i++) begin : g_err
    a_err: assert property (!$rose(err_status[i]));
  end
  c_full: cover property (full);
  c_acc_rack: cover property (rd_acc && tc_rack);
  c_both: cover property (pending_rd != '0 && pending_wr != '0);
`endif
endmodule
